// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_ctrl
//  Purpose  : Main control FSM of the multicycle RV32I core. Sequences the
//             shared datapath (ALU, immediate generator, unified memory
//             port, register file) through FETCH/DECODE/EXEC/MEM/WB, owns
//             the memory request/ready handshake and traps on illegal
//             opcodes and on memory timeouts.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    MEM_TIMEOUT   max wait cycles on mem_ready before trapping (0 = off)
//  Build option
//    CTRL_INSTRET_EN  when defined, instret counts retired instructions;
//                     when undefined, instret is tied to zero.
//  Ports
//    clk, rst_n          clock (rising edge), async active-low reset
//    instr               current IR contents
//    branch_taken        branch comparator result (valid in EXEC)
//    mem_ready           memory completes the current request this cycle
//    pc_we, pc_sel       PC write enable / source (0 ALU, 1 target adder)
//    ir_we               IR (and old_pc) write enable
//    addr_sel            memory address source (0 PC, 1 ALU out register)
//    mem_req, mem_we     memory request / write qualifier
//    reg_we              register file write enable
//    alu_src_a/b, alu_op ALU operand and operation selects
//    imm_sel             immediate format (0 I,1 S,2 B,3 U,4 J)
//    wb_sel              write-back source (0 ALU,1 mem,2 old_pc+4)
//    trap, trap_cause    sticky trap flag and cause (1 illegal, 2 timeout)
//    instret             retired-instruction count
// ============================================================================
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        branch_taken,
    input  logic        mem_ready,
    output logic        pc_we,
    output logic        pc_sel,
    output logic        ir_we,
    output logic        addr_sel,
    output logic        mem_req,
    output logic        mem_we,
    output logic        reg_we,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [2:0]  imm_sel,
    output logic [1:0]  wb_sel,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [31:0] instret
);

    localparam logic [6:0] c_op_rtype  = 7'b0110011;
    localparam logic [6:0] c_op_ialu   = 7'b0010011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_lui    = 7'b0110111;

    localparam logic [7:0] c_timeout    = 8'(MEM_TIMEOUT);
    localparam bit         c_timeout_en = (MEM_TIMEOUT != 0);

    localparam logic [1:0] c_cause_illegal = 2'd1;
    localparam logic [1:0] c_cause_timeout = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  trap_cause_q, trap_cause_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;

    logic [6:0]  w_opcode;
    logic        w_mem_phase;
    logic        w_timeout;
    logic        w_unused;

    assign w_opcode = instr[6:0];
    // Only the opcode field steers the controller; the rest of the IR is
    // consumed by the datapath.
    assign w_unused = ^instr[31:7];

    // mem_req is high exactly in FETCH and MEM, so the wait counter can be
    // derived from the state directly instead of from the output.
    assign w_mem_phase = (state_q == S_FETCH) || (state_q == S_MEM);
    assign wait_cnt_d  = (w_mem_phase && !mem_ready) ? (wait_cnt_q + 8'd1) : 8'd0;
    assign w_timeout   = c_timeout_en && (wait_cnt_q == c_timeout);

    // ------------------------------------------------------------------
    // State, trap cause and wait counter registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            trap_cause_q <= 2'd0;
            wait_cnt_q   <= 8'd0;
        end else begin
            state_q      <= state_d;
            trap_cause_q <= trap_cause_d;
            wait_cnt_q   <= wait_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        trap_cause_d = trap_cause_q;
        pc_we        = 1'b0;
        pc_sel       = 1'b0;
        ir_we        = 1'b0;
        addr_sel     = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        reg_we       = 1'b0;
        alu_src_a    = 2'd0;
        alu_src_b    = 2'd0;
        alu_op       = 2'd0;
        imm_sel      = 3'd0;
        wb_sel       = 2'd0;
        trap         = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end

            S_FETCH: begin
                // ALU computes PC+4 while the instruction is being read.
                mem_req   = 1'b1;
                alu_src_a = 2'd1;
                alu_src_b = 2'd2;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = S_DECODE;
                end else if (w_timeout) begin
                    state_d      = S_TRAP;
                    trap_cause_d = c_cause_timeout;
                end
            end

            S_DECODE: begin
                unique case (w_opcode)
                    c_op_rtype, c_op_ialu, c_op_load, c_op_store,
                    c_op_branch, c_op_jal, c_op_lui: state_d = S_EXEC;
                    default: begin
                        state_d      = S_TRAP;
                        trap_cause_d = c_cause_illegal;
                    end
                endcase
            end

            S_EXEC: begin
                unique case (w_opcode)
                    c_op_rtype: begin
                        alu_op  = 2'd2;
                        state_d = S_WB;
                    end
                    c_op_ialu: begin
                        alu_src_b = 2'd1;
                        alu_op    = 2'd2;
                        state_d   = S_WB;
                    end
                    c_op_load: begin
                        alu_src_b = 2'd1;
                        state_d   = S_MEM;
                    end
                    c_op_store: begin
                        alu_src_b = 2'd1;
                        imm_sel   = 3'd1;
                        state_d   = S_MEM;
                    end
                    c_op_branch: begin
                        // ALU subtracts for the comparator; the target adder
                        // supplies the new PC when the branch is taken.
                        alu_op  = 2'd1;
                        imm_sel = 3'd2;
                        pc_sel  = 1'b1;
                        pc_we   = branch_taken;
                        state_d = S_FETCH;
                    end
                    c_op_jal: begin
                        imm_sel = 3'd4;
                        pc_sel  = 1'b1;
                        pc_we   = 1'b1;
                        state_d = S_WB;
                    end
                    c_op_lui: begin
                        alu_src_a = 2'd2;
                        alu_src_b = 2'd1;
                        imm_sel   = 3'd3;
                        state_d   = S_WB;
                    end
                    default: begin
                        // IR changed under the controller after DECODE.
                        state_d      = S_TRAP;
                        trap_cause_d = c_cause_illegal;
                    end
                endcase
            end

            S_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = (w_opcode == c_op_store);
                if (mem_ready) begin
                    state_d = (w_opcode == c_op_store) ? S_FETCH : S_WB;
                end else if (w_timeout) begin
                    state_d      = S_TRAP;
                    trap_cause_d = c_cause_timeout;
                end
            end

            S_WB: begin
                reg_we = 1'b1;
                if (w_opcode == c_op_load) begin
                    wb_sel = 2'd1;
                end else if (w_opcode == c_op_jal) begin
                    wb_sel = 2'd2;
                end
                state_d = S_FETCH;
            end

            S_TRAP: begin
                trap = 1'b1;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign trap_cause = trap_cause_q;

    // ------------------------------------------------------------------
    // Retired-instruction counter
    // ------------------------------------------------------------------
`ifdef CTRL_INSTRET_EN
    logic [31:0] instret_q;
    logic        w_retire;

    // An instruction retires on the edge that returns the FSM to FETCH;
    // WB, store MEM and branch EXEC are the only states that do so.
    assign w_retire = (state_d == S_FETCH) &&
                      ((state_q == S_WB) || (state_q == S_MEM) || (state_q == S_EXEC));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret_q <= 32'd0;
        end else if (w_retire) begin
            instret_q <= instret_q + 32'd1;
        end
    end

    assign instret = instret_q;
`else
    assign instret = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multicycle_ctrl
//  Purpose  : Directed self-checking bench for multicycle_ctrl. A second
//             instance with MEM_TIMEOUT=4 exercises the timeout trap.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (default MEM_TIMEOUT)
    logic        rst_n, branch_taken, mem_ready;
    logic [31:0] instr;
    logic        pc_we, pc_sel, ir_we, addr_sel, mem_req, mem_we, reg_we, trap;
    logic [1:0]  alu_src_a, alu_src_b, alu_op, wb_sel, trap_cause;
    logic [2:0]  imm_sel;
    logic [31:0] instret;

    multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .branch_taken(branch_taken),
        .mem_ready(mem_ready), .pc_we(pc_we), .pc_sel(pc_sel), .ir_we(ir_we),
        .addr_sel(addr_sel), .mem_req(mem_req), .mem_we(mem_we), .reg_we(reg_we),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .imm_sel(imm_sel), .wb_sel(wb_sel), .trap(trap), .trap_cause(trap_cause),
        .instret(instret)
    );

    // Timeout instance (MEM_TIMEOUT = 4)
    logic        t_rst_n, t_mem_ready;
    logic        t_pc_we, t_pc_sel, t_ir_we, t_addr_sel, t_mem_req, t_mem_we, t_reg_we, t_trap;
    logic [1:0]  t_alu_src_a, t_alu_src_b, t_alu_op, t_wb_sel, t_trap_cause;
    logic [2:0]  t_imm_sel;
    logic [31:0] t_instret;

    multicycle_ctrl #(.MEM_TIMEOUT(4)) dut_to (
        .clk(clk), .rst_n(t_rst_n), .instr(32'h00500093), .branch_taken(1'b0),
        .mem_ready(t_mem_ready), .pc_we(t_pc_we), .pc_sel(t_pc_sel), .ir_we(t_ir_we),
        .addr_sel(t_addr_sel), .mem_req(t_mem_req), .mem_we(t_mem_we), .reg_we(t_reg_we),
        .alu_src_a(t_alu_src_a), .alu_src_b(t_alu_src_b), .alu_op(t_alu_op),
        .imm_sel(t_imm_sel), .wb_sel(t_wb_sel), .trap(t_trap), .trap_cause(t_trap_cause),
        .instret(t_instret)
    );

    // Packed view of every control output of the main instance.
    logic [31:0] obs;
    assign obs = {11'd0, pc_we, pc_sel, ir_we, addr_sel, mem_req, mem_we, reg_we,
                  alu_src_a, alu_src_b, alu_op, imm_sel, wb_sel, trap, trap_cause};

    int n_pass  = 0;
    int n_total = 0;

    // Expected-output builder, argument order matches the packed view.
    function automatic logic [31:0] mk(int pcwe, int pcsel, int irwe, int asel,
                                       int mreq, int mwe, int rwe, int sa, int sb,
                                       int aop, int imm, int wb, int trp, int tc);
        return {11'd0, 1'(pcwe), 1'(pcsel), 1'(irwe), 1'(asel), 1'(mreq), 1'(mwe),
                1'(rwe), 2'(sa), 2'(sb), 2'(aop), 3'(imm), 2'(wb), 1'(trp), 2'(tc)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        assert (got === want) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, want);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] e_fw, e_fr, e_zero, e_mem_rd;

    // From FETCH: accept the instruction, check FETCH and DECODE.
    task automatic do_fetch(input string tag, input logic [31:0] ir);
        instr     = ir;
        mem_ready = 1'b1;
        #1;
        chk({tag, "_fetch"}, obs, e_fr);
        tick();
        mem_ready = 1'b0;
        #1;
        chk({tag, "_decode"}, obs, e_zero);
    endtask

    logic [31:0] exp_instret;

    initial begin
        e_fw     = mk(0,0,0,0,1,0,0, 1,2,0,0,0, 0,0);
        e_fr     = mk(1,0,1,0,1,0,0, 1,2,0,0,0, 0,0);
        e_zero   = 32'd0;
        e_mem_rd = mk(0,0,0,1,1,0,0, 0,0,0,0,0, 0,0);

        rst_n = 1'b0; t_rst_n = 1'b0; instr = 32'd0;
        branch_taken = 1'b0; mem_ready = 1'b0; t_mem_ready = 1'b0;
        tick(); tick();
        chk("reset_outs", obs, e_zero);
        chk("reset_instret", instret, 32'd0);

        rst_n = 1'b1;
        #1;
        chk("idle_outs", obs, e_zero);
        tick();

        // ADDI x1,x0,5
        instr = 32'h00500093;
        #1;
        chk("addi_fetch_wait", obs, e_fw);
        do_fetch("addi", 32'h00500093);
        tick(); chk("addi_exec", obs, mk(0,0,0,0,0,0,0, 0,1,2,0,0, 0,0));
        tick(); chk("addi_wb",   obs, mk(0,0,0,0,0,0,1, 0,0,0,0,0, 0,0));
        tick(); chk("addi_fetch_at_4", obs, e_fw);

        // LW x2,0(x1) with three memory wait cycles
        do_fetch("lw", 32'h0000A103);
        tick(); chk("lw_exec", obs, mk(0,0,0,0,0,0,0, 0,1,0,0,0, 0,0));
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("lw_mem_wait", obs, e_mem_rd);
            tick();
        end
        mem_ready = 1'b1;
        #1;
        chk("lw_mem_rdy", obs, e_mem_rd);
        tick(); mem_ready = 1'b0; #1;
        chk("lw_wb", obs, mk(0,0,0,0,0,0,1, 0,0,0,0,1, 0,0));
        tick(); chk("lw_fetch_at_8", obs, e_fw);

        // SW x2,0(x1)
        do_fetch("sw", 32'h0020A023);
        tick(); chk("sw_exec", obs, mk(0,0,0,0,0,0,0, 0,1,0,1,0, 0,0));
        tick(); mem_ready = 1'b1; #1;
        chk("sw_mem", obs, mk(0,0,0,1,1,1,0, 0,0,0,0,0, 0,0));
        tick(); mem_ready = 1'b0; #1;
        chk("sw_fetch_at_4", obs, e_fw);

        // BEQ taken, then not taken
        do_fetch("beq_t", 32'h00208463);
        tick(); branch_taken = 1'b1; #1;
        chk("beq_t_exec", obs, mk(1,1,0,0,0,0,0, 0,0,1,2,0, 0,0));
        tick(); branch_taken = 1'b0;
        chk("beq_t_fetch_at_3", obs, e_fw);
        do_fetch("beq_n", 32'h00208463);
        tick(); chk("beq_n_exec", obs, mk(0,1,0,0,0,0,0, 0,0,1,2,0, 0,0));
        tick(); chk("beq_n_fetch_at_3", obs, e_fw);

        // JAL x0,0
        do_fetch("jal", 32'h0000006F);
        tick(); chk("jal_exec", obs, mk(1,1,0,0,0,0,0, 0,0,0,4,0, 0,0));
        tick(); chk("jal_wb",   obs, mk(0,0,0,0,0,0,1, 0,0,0,0,2, 0,0));
        tick(); chk("jal_fetch", obs, e_fw);

        // LUI x5,1
        do_fetch("lui", 32'h000012B7);
        tick(); chk("lui_exec", obs, mk(0,0,0,0,0,0,0, 2,1,0,3,0, 0,0));
        tick(); chk("lui_wb",   obs, mk(0,0,0,0,0,0,1, 0,0,0,0,0, 0,0));
        tick();

        // ADD x3,x1,x2
        do_fetch("add", 32'h002081B3);
        tick(); chk("add_exec", obs, mk(0,0,0,0,0,0,0, 0,0,2,0,0, 0,0));
        tick(); chk("add_wb",   obs, mk(0,0,0,0,0,0,1, 0,0,0,0,0, 0,0));
        tick(); chk("add_fetch", obs, e_fw);

`ifdef CTRL_INSTRET_EN
        exp_instret = 32'd8;
`else
        exp_instret = 32'd0;
`endif
        chk("instret_after_8", instret, exp_instret);

        // Illegal opcode: sticky trap, inputs ignored
        do_fetch("ill", 32'h0000007F);
        tick();
        chk("ill_trap", obs, mk(0,0,0,0,0,0,0, 0,0,0,0,0, 1,1));
        for (int i = 0; i < 20; i++) begin
            mem_ready    = 1'(i);
            branch_taken = 1'(i >> 1);
            tick();
            chk("ill_trap_hold", obs, mk(0,0,0,0,0,0,0, 0,0,0,0,0, 1,1));
        end
        mem_ready = 1'b0; branch_taken = 1'b0;
        chk("instret_no_count_in_trap", instret, exp_instret);

        // Asynchronous reset out of TRAP
        rst_n = 1'b0;
        #1;
        chk("trap_async_reset", obs, e_zero);
        chk("trap_reset_instret", instret, 32'd0);
        tick(); rst_n = 1'b1; #1;
        chk("trap_reset_idle", obs, e_zero);
        tick();

        // Reset in the middle of a memory handshake
        do_fetch("lw2", 32'h0000A103);
        tick(); tick();
        chk("lw2_mem_wait", obs, e_mem_rd);
        tick();
        rst_n = 1'b0;
        #1;
        chk("mid_mem_reset", obs, e_zero);
        tick(); rst_n = 1'b1; #1;
        chk("mid_mem_idle", obs, e_zero);
        tick();

        // Three ADDIs from a fresh reset
        for (int k = 0; k < 3; k++) begin
            do_fetch("addi_n", 32'h00500093);
            tick(); tick(); tick();
        end
        chk("addi3_fetch", obs, e_fw);
`ifdef CTRL_INSTRET_EN
        exp_instret = 32'd3;
`else
        exp_instret = 32'd0;
`endif
        chk("instret_after_3", instret, exp_instret);

        // Memory timeout on the MEM_TIMEOUT=4 instance, mem_ready held low
        t_rst_n = 1'b1;
        #1;
        chk("to_idle", {30'd0, t_mem_req, t_trap}, 32'd0);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("to_fetch_wait", {28'd0, t_mem_req, t_ir_we, t_trap, 1'b0} | {30'd0, t_trap_cause}, 32'h8);
            tick();
        end
        chk("to_trap", {27'd0, t_mem_req, t_reg_we, t_trap, t_trap_cause}, 32'h6);
        t_mem_ready = 1'b1;
        tick();
        chk("to_trap_hold", {27'd0, t_mem_req, t_pc_we, t_trap, t_trap_cause}, 32'h6);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
